// File: rtl/clock_mode_ctrl_pkg.sv
// Shared definitions for the BCD clock user-interface controller:
// mode state encoding, field one-hot masks, BCD limits and BCD helpers.
package clock_mode_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_SEC  = 3'd3,
        ST_ALM_HOUR = 3'd4,
        ST_ALM_MIN  = 3'd5
    } state_e;

    localparam logic [2:0] FLD_HOUR = 3'b100;
    localparam logic [2:0] FLD_MIN  = 3'b010;
    localparam logic [2:0] FLD_SEC  = 3'b001;
    localparam logic [2:0] FLD_NONE = 3'b000;

    localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
    localparam logic [7:0] BCD_MIN_MAX  = 8'h59;

    // Width of the shared buzzer down-counter (holds 30 s at 12 MHz).
    localparam int unsigned BEEP_CNT_W = 29;

    // Two-digit BCD increment that wraps to 00 after reaching max.
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] val, input logic [7:0] max);
        logic [7:0] res;
        if (val == max) begin
            res = 8'h00;
        end else if (val[3:0] == 4'h9) begin
            res = {val[7:4] + 4'h1, 4'h0};
        end else begin
            res = {val[7:4], val[3:0] + 4'h1};
        end
        return res;
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_key_debounce.sv
// Key debouncer: 2-flop synchronizer, stability counter, debounced level,
// one-cycle press pulse on the debounced 1->0 edge.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 240000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic held,
    output logic press
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;

    // Count consecutive cycles the synchronized key disagrees with the debounced level.
    always_comb begin
        level_d = level_q;
        cnt_d   = {CW{1'b0}};
        if (sync2_q == level_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            level_d = sync2_q;
            cnt_d   = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Synchronizer, debounce state and registered press detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            cnt_q       <= {CW{1'b0}};
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= key_n;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            press_q     <= level_dly_q & ~level_q;
        end
    end

    assign held  = ~level_q;
    assign press = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Front-panel mode controller for the BCD clock: mode FSM, generator
// freeze/adjust, alarm edit and arming, alarm buzzer and hourly chime.
module clock_mode_ctrl
    import clock_mode_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 240000,
    parameter int unsigned ALARM_CYCLES = 360000000,
    parameter int unsigned CHIME_CYCLES = 6000000,
    parameter logic [23:0] ALARM_RST    = 24'h070000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_mode_n,
    input  logic        key_adj_n,
    input  logic [23:0] time_in,
    input  logic        hour_flag,
    output logic        en,
    output logic [2:0]  control,
    output logic [23:0] alarm_time,
    output logic        alarm_on,
    output logic        disp_sel,
    output logic [2:0]  blink_mask,
    output logic        beep
);

    logic mode_held_s;
    logic mode_press_s;
    logic adj_held_s;
    logic adj_press_s;

    state_e                 state_q,      state_d;
    logic [23:0]            alarm_time_q, alarm_time_d;
    logic                   alarm_on_q,   alarm_on_d;
    logic [BEEP_CNT_W-1:0]  beep_cnt_q,   beep_cnt_d;
    logic                   beep_q,       beep_d;
    logic                   en_q,         en_d;
    logic [2:0]             control_q,    control_d;
    logic                   disp_sel_q,   disp_sel_d;
    logic [2:0]             blink_mask_q, blink_mask_d;
    logic                   match_q;
    logic                   match_prev_q;
    logic                   chime_q;

    logic in_set_s;
    logic match_now_s;
    logic match_rise_s;
    logic beeping_s;
    logic key_ev_s;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_mode_n),
        .held  (mode_held_s),
        .press (mode_press_s)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_adj (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_adj_n),
        .held  (adj_held_s),
        .press (adj_press_s)
    );

    // Alarm match level, its rising edge, and key-event summary.
    always_comb begin
        in_set_s     = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN) || (state_q == ST_SET_SEC);
        match_now_s  = alarm_on_q && !in_set_s &&
                       (time_in[23:8] == alarm_time_q[23:8]) && (time_in[7:0] == 8'h00);
        match_rise_s = match_q && !match_prev_q && !in_set_s;
        beeping_s    = (beep_cnt_q != {BEEP_CNT_W{1'b0}});
        key_ev_s     = mode_press_s || adj_press_s;
    end

    // Mode FSM next state, alarm edit and arming; presses during a beep only silence it.
    always_comb begin
        state_d      = state_q;
        alarm_time_d = alarm_time_q;
        alarm_on_d   = alarm_on_q;
        if (beeping_s && key_ev_s) begin
            state_d = state_q;
        end else if (mode_press_s) begin
            case (state_q)
                ST_RUN:      state_d = ST_SET_HOUR;
                ST_SET_HOUR: state_d = ST_SET_MIN;
                ST_SET_MIN:  state_d = ST_SET_SEC;
                ST_SET_SEC:  state_d = ST_ALM_HOUR;
                ST_ALM_HOUR: state_d = ST_ALM_MIN;
                ST_ALM_MIN:  state_d = ST_RUN;
                default:     state_d = ST_RUN;
            endcase
        end else if (adj_press_s) begin
            case (state_q)
                ST_RUN:      alarm_on_d = ~alarm_on_q;
                ST_ALM_HOUR: alarm_time_d[23:16] = bcd_inc_wrap(alarm_time_q[23:16], BCD_HOUR_MAX);
                ST_ALM_MIN:  alarm_time_d[15:8]  = bcd_inc_wrap(alarm_time_q[15:8], BCD_MIN_MAX);
                default:     alarm_on_d = alarm_on_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Buzzer counter: alarm load beats key silence beats chime load beats countdown.
    always_comb begin
        beep_cnt_d = beep_cnt_q;
        if (match_rise_s) begin
            beep_cnt_d = BEEP_CNT_W'(ALARM_CYCLES);
        end else if (beeping_s && key_ev_s) begin
            beep_cnt_d = {BEEP_CNT_W{1'b0}};
        end else if (chime_q && !beeping_s) begin
            beep_cnt_d = BEEP_CNT_W'(CHIME_CYCLES);
        end else if (beeping_s) begin
            beep_cnt_d = beep_cnt_q - {{(BEEP_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            beep_cnt_d = beep_cnt_q;
        end
        beep_d = (beep_cnt_d != {BEEP_CNT_W{1'b0}});
    end

    // Generator and display controls decoded from the current mode and adj hold.
    always_comb begin
        en_d         = 1'b1;
        control_d    = 3'b111;
        disp_sel_d   = 1'b0;
        blink_mask_d = FLD_NONE;
        case (state_q)
            ST_RUN: begin
                en_d = 1'b1;
            end
            ST_SET_HOUR: begin
                en_d         = adj_held_s;
                control_d    = adj_held_s ? ~FLD_HOUR : 3'b111;
                blink_mask_d = FLD_HOUR;
            end
            ST_SET_MIN: begin
                en_d         = adj_held_s;
                control_d    = adj_held_s ? ~FLD_MIN : 3'b111;
                blink_mask_d = FLD_MIN;
            end
            ST_SET_SEC: begin
                en_d         = adj_held_s;
                control_d    = adj_held_s ? ~FLD_SEC : 3'b111;
                blink_mask_d = FLD_SEC;
            end
            ST_ALM_HOUR: begin
                disp_sel_d   = 1'b1;
                blink_mask_d = FLD_HOUR;
            end
            ST_ALM_MIN: begin
                disp_sel_d   = 1'b1;
                blink_mask_d = FLD_MIN;
            end
            default: begin
                en_d = 1'b1;
            end
        endcase
    end

    // State, alarm, buzzer and registered output updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            alarm_time_q <= ALARM_RST;
            alarm_on_q   <= 1'b0;
            beep_cnt_q   <= {BEEP_CNT_W{1'b0}};
            beep_q       <= 1'b0;
            en_q         <= 1'b1;
            control_q    <= 3'b111;
            disp_sel_q   <= 1'b0;
            blink_mask_q <= FLD_NONE;
            chime_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_time_q <= alarm_time_d;
            alarm_on_q   <= alarm_on_d;
            beep_cnt_q   <= beep_cnt_d;
            beep_q       <= beep_d;
            en_q         <= en_d;
            control_q    <= control_d;
            disp_sel_q   <= disp_sel_d;
            blink_mask_q <= blink_mask_d;
            chime_q      <= hour_flag && (state_q == ST_RUN);
        end
    end

    // Match edge detector; held clear while setting the time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q      <= 1'b0;
            match_prev_q <= 1'b0;
        end else if (in_set_s) begin
            match_q      <= 1'b0;
            match_prev_q <= 1'b0;
        end else begin
            match_q      <= match_now_s;
            match_prev_q <= match_q;
        end
    end

    assign en         = en_q;
    assign control    = control_q;
    assign alarm_time = alarm_time_q;
    assign alarm_on   = alarm_on_q;
    assign disp_sel   = disp_sel_q;
    assign blink_mask = blink_mask_q;
    assign beep       = beep_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl with short debounce/beep timings.
module tb_clock_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_mode_n;
    logic        key_adj_n;
    logic [23:0] time_in;
    logic        hour_flag;
    logic        en;
    logic [2:0]  control;
    logic [23:0] alarm_time;
    logic        alarm_on;
    logic        disp_sel;
    logic [2:0]  blink_mask;
    logic        beep;

    int n_chk = 0;
    int n_err = 0;

    clock_mode_ctrl #(
        .DEB_CYCLES   (4),
        .ALARM_CYCLES (100),
        .CHIME_CYCLES (10),
        .ALARM_RST    (24'h070000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_mode_n (key_mode_n),
        .key_adj_n  (key_adj_n),
        .time_in    (time_in),
        .hour_flag  (hour_flag),
        .en         (en),
        .control    (control),
        .alarm_time (alarm_time),
        .alarm_on   (alarm_on),
        .disp_sel   (disp_sel),
        .blink_mask (blink_mask),
        .beep       (beep)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hold;
        logic [2:0] blink;
        logic       disp;
        logic       en_idle;
        logic [2:0] ctrl_held;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_mode();
        key_mode_n = 1'b0;
        cyc(10);
        key_mode_n = 1'b1;
        cyc(12);
    endtask

    task automatic press_adj();
        key_adj_n = 1'b0;
        cyc(10);
        key_adj_n = 1'b1;
        cyc(12);
    endtask

    // Count consecutive sampled cycles with beep high, bounded.
    task automatic count_beep(output int cnt);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (beep) cnt++;
            else break;
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        int cnt;
        int hour_m;
        int min_m;
        int n;

        vecs[0] = '{1'b1, 3'b100, 1'b0, 1'b0, 3'b011};
        vecs[1] = '{1'b1, 3'b010, 1'b0, 1'b0, 3'b101};
        vecs[2] = '{1'b1, 3'b001, 1'b0, 1'b0, 3'b110};
        vecs[3] = '{1'b0, 3'b100, 1'b1, 1'b1, 3'b111};
        vecs[4] = '{1'b0, 3'b010, 1'b1, 1'b1, 3'b111};
        vecs[5] = '{1'b0, 3'b000, 1'b0, 1'b1, 3'b111};

        rst_n      = 1'b0;
        key_mode_n = 1'b1;
        key_adj_n  = 1'b1;
        time_in    = 24'h120000;
        hour_flag  = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        // Reset values
        chk("rst_en", en, 1);
        chk("rst_control", control, 3'b111);
        chk("rst_alarm_time", alarm_time, 24'h070000);
        chk("rst_alarm_on", alarm_on, 0);
        chk("rst_disp_sel", disp_sel, 0);
        chk("rst_blink", blink_mask, 3'b000);
        chk("rst_beep", beep, 0);

        // Short glitch is filtered
        key_mode_n = 1'b0;
        cyc(2);
        key_mode_n = 1'b1;
        cyc(15);
        chk("glitch_blink", blink_mask, 3'b000);
        chk("glitch_en", en, 1);

        // Walk the mode ring; hold adj in the time-set modes
        for (int i = 0; i < 6; i++) begin
            press_mode();
            chk($sformatf("walk%0d_blink", i), blink_mask, vecs[i].blink);
            chk($sformatf("walk%0d_disp", i), disp_sel, vecs[i].disp);
            chk($sformatf("walk%0d_en", i), en, vecs[i].en_idle);
            chk($sformatf("walk%0d_ctrl", i), control, 3'b111);
            if (vecs[i].hold) begin
                key_adj_n = 1'b0;
                cyc(10);
                chk($sformatf("walk%0d_ctrl_held", i), control, vecs[i].ctrl_held);
                chk($sformatf("walk%0d_en_held", i), en, 1);
                key_adj_n = 1'b1;
                cyc(12);
                chk($sformatf("walk%0d_ctrl_rel", i), control, 3'b111);
                chk($sformatf("walk%0d_en_rel", i), en, 0);
            end
        end
        chk("walk_alarm_unchanged", alarm_time, 24'h070000);

        // Match with alarm disarmed does nothing
        time_in = 24'h070000;
        cyc(6);
        chk("disarmed_no_beep", beep, 0);
        time_in = 24'h120000;
        cyc(3);

        // Arm, then alarm match
        press_adj();
        chk("armed", alarm_on, 1);
        time_in = 24'h070000;
        cyc(2);
        count_beep(cnt);
        chk("alarm_len", cnt, 100);
        cyc(20);
        chk("no_retrigger", beep, 0);

        // Chime
        time_in = 24'h120000;
        cyc(3);
        hour_flag = 1'b1;
        cyc(1);
        hour_flag = 1'b0;
        cyc(1);
        count_beep(cnt);
        chk("chime_len", cnt, 10);

        // Alarm overrides a running chime
        cyc(3);
        hour_flag = 1'b1;
        cyc(1);
        hour_flag = 1'b0;
        cyc(3);
        time_in = 24'h070000;
        cyc(2);
        count_beep(cnt);
        chk("alarm_over_chime", cnt, 100);

        // Mode press during a beep only silences it
        time_in = 24'h120000;
        cyc(3);
        time_in = 24'h070000;
        cyc(5);
        chk("beep_before_mode", beep, 1);
        press_mode();
        chk("mode_silence_beep", beep, 0);
        chk("mode_consumed", blink_mask, 3'b000);
        chk("mode_consumed_en", en, 1);

        // Adj press during a beep does not toggle arming
        time_in = 24'h120000;
        cyc(3);
        time_in = 24'h070000;
        cyc(5);
        press_adj();
        chk("adj_silence_beep", beep, 0);
        chk("adj_consumed", alarm_on, 1);

        // Alarm editing against an arithmetic model
        time_in = 24'h123456;
        repeat (4) press_mode();
        chk("alm_hour_disp", disp_sel, 1);
        chk("alm_hour_blink", blink_mask, 3'b100);
        hour_m = 7;
        min_m  = 0;
        n = $urandom_range(1, 20);
        repeat (n) press_adj();
        hour_m = (hour_m + n) % 24;
        chk("alm_hour_rand", alarm_time, {to_bcd(hour_m), to_bcd(min_m), 8'h00});
        n = (23 - hour_m + 24) % 24;
        repeat (n) press_adj();
        hour_m = 23;
        chk("alm_hour_23", alarm_time, {to_bcd(hour_m), to_bcd(min_m), 8'h00});
        press_adj();
        chk("alm_hour_wrap", alarm_time, 24'h000000);

        press_mode();
        chk("alm_min_blink", blink_mask, 3'b010);
        n = $urandom_range(1, 20);
        repeat (n) press_adj();
        min_m = n % 60;
        chk("alm_min_rand", alarm_time, {to_bcd(0), to_bcd(min_m), 8'h00});
        n = 59 - min_m;
        repeat (n) press_adj();
        chk("alm_min_59", alarm_time, 24'h005900);
        press_adj();
        chk("alm_min_wrap", alarm_time, 24'h000000);
        press_mode();
        chk("back_to_run", blink_mask, 3'b000);

        // Asynchronous reset in SET_HOUR with adj held
        press_mode();
        key_adj_n = 1'b0;
        cyc(10);
        chk("pre_rst_ctrl", control, 3'b011);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", control, 3'b111);
        chk("async_rst_en", en, 1);
        chk("async_rst_blink", blink_mask, 3'b000);
        chk("async_rst_alarm_on", alarm_on, 0);
        chk("async_rst_alarm", alarm_time, 24'h070000);
        chk("async_rst_beep", beep, 0);
        key_adj_n = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(15);
        chk("post_rst_blink", blink_mask, 3'b000);
        chk("post_rst_ctrl", control, 3'b111);
        chk("post_rst_en", en, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

User-interface controller for the 12 MHz BCD clock. It debounces the two front-panel keys and runs a mode state machine that freezes and adjusts the time generator through its `en` and active-low `control[2:0]` inputs. It also holds and edits an alarm time, and drives the alarm buzzer and the hourly chime from the generator's `time_out` and `flag` outputs. The display mux sits downstream and consumes `disp_sel` and `blink_mask`.

## Interface
- `DEB_CYCLES`, 240000: key stable time, 20 ms at 12 MHz.
- `ALARM_CYCLES`, 360000000: buzzer duration on an alarm match, 30 s.
- `CHIME_CYCLES`, 6000000: buzzer duration on a top-of-hour flag, 0.5 s.
- `ALARM_RST`, 24'h070000: reset alarm time, BCD hh:mm:ss.
- `clk`  in  1: 12 MHz system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `key_mode_n`  in  1: raw mode button, active-low, asynchronous.
- `key_adj_n`  in  1: raw adjust button, active-low, asynchronous.
- `time_in`  in  24: current time from the generator, BCD {hh,mm,ss}.
- `hour_flag`  in  1: one-cycle top-of-hour pulse from the generator.
- `en`  out  1: generator run enable.
- `control`  out  3: generator per-field adjust, active-low, bits {hour,min,sec}.
- `alarm_time`  out  24: alarm setting, BCD; seconds are always 00.
- `alarm_on`  out  1: alarm armed.
- `disp_sel`  out  1: 1 shows `alarm_time`, 0 shows `time_in`.
- `blink_mask`  out  3: one-hot field being edited, {hour,min,sec}.
- `beep`  out  1: buzzer drive, active-high.

## Operation
- **Debounce.** Each key uses a 2-flop synchronizer followed by a counter.
  - The debounced level changes only after the raw input has been stable for `DEB_CYCLES` consecutive cycles.
  - A `press` pulse lasts one cycle, on the debounced 1→0 edge.
  - `held` equals the debounced level inverted.
- **FSM states:** RUN → SET_HOUR → SET_MIN → SET_SEC → ALM_HOUR → ALM_MIN → RUN. Each mode press advances one state.
- **RUN**
  - `en` = 1, `control` = 111, `disp_sel` = 0, `blink_mask` = 000.
  - An adj press toggles `alarm_on`.
- **SET_HOUR / SET_MIN / SET_SEC**
  - `disp_sel` = 0. `blink_mask` = 100 / 010 / 001 respectively.
  - `en` = adj held, so the clock is frozen while the user is not adjusting.
  - The selected `control` bit = 0 while adj is held; the other bits = 1. The generator then steps that field at its 5 Hz rate.
- **ALM_HOUR / ALM_MIN**
  - `en` = 1, `control` = 111, `disp_sel` = 1, `blink_mask` = 100 / 010.
  - Each adj press increments the alarm field in BCD by 1. Hours wrap 23→00; minutes wrap 59→00 with no carry into hours.
- **Beep**
  - One down-counter, 29 bits, sized for `ALARM_CYCLES`.
  - **Alarm match:** in RUN or ALM_*, with `alarm_on` = 1, a rising edge of (`time_in[23:8]` == `alarm_time[23:8]` && `time_in[7:0]` == 0) loads `ALARM_CYCLES`.
  - **Chime:** `hour_flag` in RUN loads `CHIME_CYCLES`, but only if the counter is 0.
  - `beep` = (counter ≠ 0).
- **Priorities and simultaneous events**
  - An alarm overrides a running chime and reloads the counter.
  - A mode press and an adj press in the same cycle: mode wins, adj is dropped.
  - Any key press while `beep` = 1 clears the counter and is consumed: no state change, no toggle.
  - No matches are detected in SET_*, and the match edge detector is cleared there. Leaving SET_SEC at exactly the alarm time therefore still fires.

## Timing
- **Reset values:** state RUN, `en` = 1, `control` = 111, `alarm_time` = `ALARM_RST`, `alarm_on` = 0, `disp_sel` = 0, `blink_mask` = 000, `beep` = 0, counters 0.
- **Latency**
  - Raw edge to `press`: `DEB_CYCLES` + 3 cycles.
  - `press` to new state: 1 cycle.
  - State or held to the registered `en`/`control`/`disp_sel`/`blink_mask`: 1 further cycle.
  - Match edge or `hour_flag` to `beep` high: 2 cycles.
  - A key press to `beep` low: 1 cycle after `press`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Reset mid-operation:** an asynchronous return to the reset values, including a mid-beep or mid-adjust reset. `control` is released to 111 immediately.

## Structure
- Shared clock package holds:
  - the state encoding enum (3 bits);
  - the field one-hot constants `FLD_HOUR` = 100, `FLD_MIN` = 010, `FLD_SEC` = 001;
  - the BCD max constants 8'h23 and 8'h59;
  - a BCD increment-with-wrap function.
- One sub-module, `key_debounce` (parameter `DEB_CYCLES`; outputs `held` and `press`), instantiated twice.

## Test plan
Use `DEB_CYCLES` = 4, `ALARM_CYCLES` = 100 and `CHIME_CYCLES` = 10.
1. A 2-cycle glitch on `key_mode_n` → no `press`, state stays RUN. A 10-cycle low → exactly one `press`, then `blink_mask` = 100 and `en` = 0.
2. In SET_MIN, hold adj → `control` = 101 and `en` = 1 while held. Release → `control` = 111 and `en` = 0.
3. In ALM_HOUR from alarm 23:00, one adj press → `alarm_time` = 24'h000000. In ALM_MIN from 59, one press → minutes 00, hour unchanged.
4. With `alarm_on` = 1 and alarm 07:00, drive `time_in` = 24'h070000 in RUN → `beep` high for 100 cycles. Holding the match level → no retrigger.
5. `hour_flag` pulse → `beep` high for 10 cycles. A match arriving during the chime → reload to 100. A mode press during the beep → `beep` low, state still RUN.
6. Assert `rst_n` low while in SET_HOUR with adj held → outputs at reset values immediately. Release → RUN, `control` = 111.
